// File: rtl/mem_burst_responder_pkg.sv
// Shared constants and state encoding for the cache-fill burst responder.
package mem_burst_responder_pkg;

    localparam int BLOCK_WORDS = 8;   // 16-bit words per 16-byte block
    localparam int BEAT_W      = 3;   // beat index width
    localparam int WAIT_W      = 4;   // access-latency counter width (LATENCY <= 15)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_e;

endpackage

// File: rtl/dff.sv
// Generic codebase flop: async active-low reset to zero, write enable.
module dff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         wen_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    // Register with asynchronous clear and load enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (wen_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/mem_word_array.sv
// Main memory word array: one synchronous write port, one combinational read port.
module mem_word_array #(
    parameter int IDX_W  = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**IDX_W];

    // NOTE: the storage array has no reset; its contents are preloaded data that must survive rst.
    // Word write on the rising edge.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // A same-cycle write is not yet visible here, so a colliding read sees the old word.
    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/mem_burst_responder.sv
// Cache line fill responder: accepts a block read, waits LATENCY cycles, then
// returns the 16-byte block as eight registered 16-bit beats.
module mem_burst_responder
    import mem_burst_responder_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    output logic        busy,
    output logic [15:0] memory_data,
    output logic        memory_data_valid,
    output logic [2:0]  memory_beat,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data
);

    localparam int IDX_W  = ADDR_BITS - 1;
    localparam int BASE_W = IDX_W - BEAT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LATENCY - 1);

    state_e              state_d, state_q;
    logic [1:0]          state_raw_q;
    logic [WAIT_W-1:0]   cnt_d, cnt_q;
    logic [BASE_W-1:0]   base_d, base_q;
    logic [BEAT_W-1:0]   beat_d, beat_q;
    logic                busy_d, busy_q;
    logic                valid_d, valid_q;
    logic [15:0]         data_d, data_q;
    logic [IDX_W-1:0]    rd_idx, wr_idx;
    logic [15:0]         rd_data;
    logic                unused_ok;

    // Byte offsets within a word/block and any aliased upper bits are dropped.
    assign unused_ok = ^{req_addr, wr_addr};
    assign wr_idx    = wr_addr[ADDR_BITS-1:1];

    mem_word_array #(
        .IDX_W (IDX_W),
        .DATA_W(16)
    ) u_array (
        .clk_i    (clk),
        .wr_en_i  (wr_en),
        .wr_idx_i (wr_idx),
        .wr_data_i(wr_data),
        .rd_idx_i (rd_idx),
        .rd_data_o(rd_data)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    // Next-state logic: request acceptance, latency countdown, beat sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        beat_d  = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d = req_addr[ADDR_BITS-1:BEAT_W+1];
                    cnt_d  = WAIT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = BURST;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - WAIT_W'(1);
                if (cnt_q == WAIT_W'(1)) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values, so the array is read one cycle ahead.
    assign rd_idx  = {base_d, beat_d};
    assign valid_d = (state_d == BURST);
    assign busy_d  = (state_d != IDLE);
    assign data_d  = valid_d ? rd_data : 16'h0000;

    dff #(.W(2))      u_state (.clk_i(clk), .rst_ni(rst), .wen_i(1'b1), .d_i(state_d), .q_o(state_raw_q));
    dff #(.W(WAIT_W)) u_cnt   (.clk_i(clk), .rst_ni(rst), .wen_i(1'b1), .d_i(cnt_d),   .q_o(cnt_q));
    dff #(.W(BASE_W)) u_base  (.clk_i(clk), .rst_ni(rst), .wen_i(1'b1), .d_i(base_d),  .q_o(base_q));
    dff #(.W(BEAT_W)) u_beat  (.clk_i(clk), .rst_ni(rst), .wen_i(1'b1), .d_i(beat_d),  .q_o(beat_q));
    dff #(.W(1))      u_busy  (.clk_i(clk), .rst_ni(rst), .wen_i(1'b1), .d_i(busy_d),  .q_o(busy_q));
    dff #(.W(1))      u_valid (.clk_i(clk), .rst_ni(rst), .wen_i(1'b1), .d_i(valid_d), .q_o(valid_q));
    dff #(.W(16))     u_data  (.clk_i(clk), .rst_ni(rst), .wen_i(1'b1), .d_i(data_d),  .q_o(data_q));

    assign state_q           = state_e'(state_raw_q);
    assign busy              = busy_q;
    assign memory_data_valid = valid_q;
    assign memory_data       = data_q;
    assign memory_beat       = beat_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Self-checking bench for mem_burst_responder: LATENCY=4 and LATENCY=1 instances
// share stimulus; a timeline reference model plus table and directed checks.
module tb_mem_burst_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    logic        busy0, valid0, busy1, valid1;
    logic [15:0] data0, data1;
    logic [2:0]  beat0, beat1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: shadow memory and, per instance, cycles since acceptance (-1 = none).
    logic [15:0] mem_model [0:32767];
    int          t_m [2];
    logic [11:0] base_m [2];
    logic        exp_busy [2];
    logic        exp_valid [2];
    logic [15:0] exp_data [2];
    logic [2:0]  exp_beat [2];

    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic        busy;
        logic        valid;
        logic [15:0] data;
        logic [2:0]  beat;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    mem_burst_responder #(.LATENCY(4), .ADDR_BITS(16)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .busy(busy0), .memory_data(data0), .memory_data_valid(valid0), .memory_beat(beat0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    mem_burst_responder #(.LATENCY(1), .ADDR_BITS(16)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .busy(busy1), .memory_data(data1), .memory_data_valid(valid1), .memory_beat(beat1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    function automatic int lat_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [15:0] pv(int w);
        return 16'(32'hA000 + w - 32);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict outputs after the coming edge from the current inputs, then apply the write.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int l;
            l = lat_of(i);
            if (!rst) begin
                t_m[i] = -1;
            end else begin
                if ((t_m[i] < 0 || t_m[i] >= l + 8) && req_valid) begin
                    t_m[i]    = 0;
                    base_m[i] = req_addr[15:4];
                end else if (t_m[i] >= l + 8) begin
                    t_m[i] = -1;
                end
                if (t_m[i] >= 0) t_m[i]++;
            end
            exp_busy[i]  = (t_m[i] >= 1) && (t_m[i] <= l + 7);
            exp_valid[i] = (t_m[i] >= l) && (t_m[i] <= l + 7);
            exp_beat[i]  = exp_valid[i] ? 3'(t_m[i] - l) : 3'd0;
            exp_data[i]  = exp_valid[i] ? mem_model[{base_m[i], exp_beat[i]}] : 16'h0000;
        end
        if (wr_en) mem_model[wr_addr[15:1]] = wr_data;
    endtask

    task automatic compare_model();
        check("model busy L4",  32'(busy0),  32'(exp_busy[0]));
        check("model valid L4", 32'(valid0), 32'(exp_valid[0]));
        check("model data L4",  32'(data0),  32'(exp_data[0]));
        check("model beat L4",  32'(beat0),  32'(exp_beat[0]));
        check("model busy L1",  32'(busy1),  32'(exp_busy[1]));
        check("model valid L1", 32'(valid1), 32'(exp_valid[1]));
        check("model data L1",  32'(data1),  32'(exp_data[1]));
        check("model beat L1",  32'(beat1),  32'(exp_beat[1]));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        wr_en     = 1'b0;
        wr_addr   = 16'h0000;
        wr_data   = 16'h0000;
    endtask

    task automatic check_zero_l4(input string tag);
        check({tag, " busy"},  32'(busy0),  32'd0);
        check({tag, " valid"}, 32'(valid0), 32'd0);
        check({tag, " data"},  32'(data0),  32'd0);
        check({tag, " beat"},  32'(beat0),  32'd0);
    endtask

    // Row i: inputs during cycle i, expected LATENCY=4 outputs during cycle i+1.
    task automatic run_table();
        for (int i = 0; i < 13; i++) begin
            req_valid = tbl[i].req;
            req_addr  = tbl[i].addr;
            tick();
            check($sformatf("tbl[%0d] busy", i),  32'(busy0),  32'(tbl[i].busy));
            check($sformatf("tbl[%0d] valid", i), 32'(valid0), 32'(tbl[i].valid));
            check($sformatf("tbl[%0d] data", i),  32'(data0),  32'(tbl[i].data));
            check($sformatf("tbl[%0d] beat", i),  32'(beat0),  32'(tbl[i].beat));
        end
        req_valid = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 16'hFFF0 | 16'($urandom_range(0, 15));
        return 16'($urandom_range(0, 255));
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout: got still running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        tbl[0]  = '{1'b1, 16'h0046, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA000, 3'd0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA001, 3'd1};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA002, 3'd2};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA003, 3'd3};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA004, 3'd4};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA005, 3'd5};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA006, 3'd6};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA007, 3'd7};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'd0};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'd0};

        t_m[0] = -1;
        t_m[1] = -1;
        for (int w = 0; w < 32768; w++) mem_model[w] = 16'h0000;

        rst = 1'b0;
        idle_inputs();
        #2;
        check_zero_l4("reset L4");
        check("reset busy L1",  32'(busy1),  32'd0);
        check("reset valid L1", 32'(valid1), 32'd0);
        check("reset data L1",  32'(data1),  32'd0);
        check("reset beat L1",  32'(beat1),  32'd0);

        // Preload; the first few writes land while reset is still held.
        for (int w = 0; w < 128; w++) begin
            if (w == 4) rst = 1'b1;
            wr_en   = 1'b1;
            wr_addr = 16'(w * 2);
            wr_data = pv(w);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            wr_en   = 1'b1;
            wr_addr = 16'hFFF0 + 16'(k * 2);
            wr_data = 16'hF000 + 16'(k);
            tick();
        end
        idle_inputs();
        ticks(2);

        // Basic fill at LATENCY=4, low address bits ignored.
        run_table();
        ticks(2);

        // LATENCY=1 at the top of the address space.
        req_valid = 1'b1;
        req_addr  = 16'hFFF0;
        tick();
        req_valid = 1'b0;
        check("L1 first beat valid", 32'(valid1), 32'd1);
        check("L1 first beat data",  32'(data1),  32'h0000F000);
        ticks(7);
        check("L1 last beat index", 32'(beat1), 32'd7);
        check("L1 last beat data",  32'(data1), 32'h0000F007);
        tick();
        check("L1 busy drops cycle 9", 32'(busy1), 32'd0);
        ticks(4);

        // Request held high: back-to-back bursts, re-acceptance only when idle.
        req_valid = 1'b1;
        req_addr  = 16'h0046;
        for (int c = 1; c <= 25; c++) begin
            tick();
            check($sformatf("b2b busy c%0d", c), 32'(busy0), 32'((c % 12) != 0));
            if (c == 16) begin
                check("b2b second burst valid", 32'(valid0), 32'd1);
                check("b2b second burst beat",  32'(beat0),  32'd0);
            end
        end
        req_valid = 1'b0;
        ticks(14);

        // Writes into the active block during the burst.
        req_valid = 1'b1;
        req_addr  = 16'h0080;
        tick();
        req_valid = 1'b0;
        ticks(3);
        check("wr-coll beat0 data", 32'(data0), 32'h0000A020);
        tick();
        check("wr-coll beat1 sent", 32'(data0), 32'h0000A021);
        tick();
        check("wr-coll at beat2", 32'(beat0), 32'd2);
        wr_en = 1'b1; wr_addr = 16'h008A; wr_data = 16'h1234;
        tick();
        wr_addr = 16'h0082; wr_data = 16'h5555;
        tick();
        wr_en = 1'b0;
        tick();
        check("wr-coll beat5 new", 32'(data0), 32'h00001234);
        check("wr-coll beat5 idx", 32'(beat0), 32'd5);
        wr_en = 1'b1; wr_addr = 16'h008C; wr_data = 16'h7777;
        tick();
        wr_en = 1'b0;
        check("wr-coll same-cycle old", 32'(data0), 32'h0000A026);
        ticks(5);

        // Reset mid-burst at beat 3.
        req_valid = 1'b1;
        req_addr  = 16'h0046;
        tick();
        req_valid = 1'b0;
        ticks(6);
        check("rst-abort at beat3", 32'(beat0), 32'd3);
        rst = 1'b0;
        #1;
        check_zero_l4("rst-abort async");
        tick();
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("rst-abort no beats", 32'(valid0), 32'd0);
        end
        run_table();
        ticks(2);

        // Long idle.
        for (int c = 0; c < 20; c++) begin
            tick();
            check_zero_l4("idle");
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 9) < 3);
            req_addr  = rand_addr();
            wr_en     = ($urandom_range(0, 9) < 3);
            wr_addr   = rand_addr();
            wr_data   = 16'($urandom);
            rst       = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst = 1'b1;
        idle_inputs();
        ticks(15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
